datamem_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the single-port `data_memory` block. It accepts read and write requests from two clients, for example the CPU load/store unit and a debug/DMA loader. It issues one command at a time onto the memory's `write`/`read`/`address`/`data_in` port and returns read data with a valid pulse to the winning client. It sits between the clients and `data_memory`, and is the only driver of the memory's control inputs.

---
 rtl/datamem_arbiter_if.sv | 26 ++
 rtl/datamem_arbiter.sv | 139 +++++++++++++
 tb/tb_datamem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/datamem_arbiter_if.sv
// Client request/response and data_memory command signals shared by the arbiter and its surroundings.
// The arbiter connects through the slave modport; whatever drives clients and memory uses master.
interface datamem_arbiter_if;
  logic        req0, req1;
  logic        we0, we1;
  logic [31:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1;
  logic        rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic        mem_write, mem_read;
  logic [31:0] mem_address, mem_data_in;
  logic [31:0] mem_data_out;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_write, mem_read, mem_address, mem_data_in
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_write, mem_read, mem_address, mem_data_in
  );
endinterface

// File: rtl/datamem_arbiter.sv
// Round-robin arbiter/sequencer letting two clients share the single-port data_memory.
// One command in flight; a read waits MEM_LAT cycles and returns data with an rvalid pulse.
module datamem_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  datamem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT, S_RESP} state_t;

  state_t      r_state, w_state_next;
  logic        r_last, w_last_next;
  logic        r_winner, w_winner_next;
  logic [1:0]  r_count, w_count_next;
  logic        r_gnt0, w_gnt0_next;
  logic        r_gnt1, w_gnt1_next;
  logic        r_rvalid0, w_rvalid0_next;
  logic        r_rvalid1, w_rvalid1_next;
  logic        r_mem_write, w_mem_write_next;
  logic        r_mem_read, w_mem_read_next;
  logic [31:0] r_mem_address, w_mem_address_next;
  logic [31:0] r_mem_data_in, w_mem_data_in_next;
  logic [31:0] r_rdata0, w_rdata0_next;
  logic [31:0] r_rdata1, w_rdata1_next;

  logic w_any_req;
  logic w_pick;
  logic w_pick_we;

  // On a tie the client not granted last wins; a lone requester always wins.
  assign w_any_req = bus.req0 | bus.req1;
  assign w_pick    = (bus.req0 & bus.req1) ? ~r_last : bus.req1;
  assign w_pick_we = w_pick ? bus.we1 : bus.we0;

  always_comb begin
    w_state_next       = r_state;
    w_last_next        = r_last;
    w_winner_next      = r_winner;
    w_count_next       = r_count;
    w_gnt0_next        = 1'b0;
    w_gnt1_next        = 1'b0;
    w_rvalid0_next     = 1'b0;
    w_rvalid1_next     = 1'b0;
    w_mem_write_next   = 1'b0;
    w_mem_read_next    = 1'b0;
    w_mem_address_next = r_mem_address;
    w_mem_data_in_next = r_mem_data_in;
    w_rdata0_next      = r_rdata0;
    w_rdata1_next      = r_rdata1;

    case (r_state)
      S_IDLE: begin
        // Outputs are registered, so the whole GRANT-cycle command is set up here.
        if (w_any_req) begin
          w_state_next       = S_GRANT;
          w_winner_next      = w_pick;
          w_last_next        = w_pick;
          w_gnt0_next        = ~w_pick;
          w_gnt1_next        = w_pick;
          w_mem_write_next   = w_pick_we;
          w_mem_read_next    = ~w_pick_we;
          w_mem_address_next = w_pick ? bus.addr1 : bus.addr0;
          w_mem_data_in_next = w_pick ? bus.wdata1 : bus.wdata0;
        end
      end
      S_GRANT: begin
        if (r_mem_write) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_WAIT;
          w_count_next = 2'(MEM_LAT - 1);
        end
      end
      S_WAIT: begin
        if (r_count == 2'd0) begin
          w_state_next = S_RESP;
          if (r_winner) begin
            w_rdata1_next  = bus.mem_data_out;
            w_rvalid1_next = 1'b1;
          end else begin
            w_rdata0_next  = bus.mem_data_out;
            w_rvalid0_next = 1'b1;
          end
        end else begin
          w_count_next = r_count - 2'd1;
        end
      end
      S_RESP: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_last        <= 1'b1;
      r_winner      <= 1'b0;
      r_count       <= 2'd0;
      r_gnt0        <= 1'b0;
      r_gnt1        <= 1'b0;
      r_rvalid0     <= 1'b0;
      r_rvalid1     <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_address <= 32'd0;
      r_mem_data_in <= 32'd0;
      r_rdata0      <= 32'd0;
      r_rdata1      <= 32'd0;
    end else begin
      r_state       <= w_state_next;
      r_last        <= w_last_next;
      r_winner      <= w_winner_next;
      r_count       <= w_count_next;
      r_gnt0        <= w_gnt0_next;
      r_gnt1        <= w_gnt1_next;
      r_rvalid0     <= w_rvalid0_next;
      r_rvalid1     <= w_rvalid1_next;
      r_mem_write   <= w_mem_write_next;
      r_mem_read    <= w_mem_read_next;
      r_mem_address <= w_mem_address_next;
      r_mem_data_in <= w_mem_data_in_next;
      r_rdata0      <= w_rdata0_next;
      r_rdata1      <= w_rdata1_next;
    end
  end

  assign bus.gnt0        = r_gnt0;
  assign bus.gnt1        = r_gnt1;
  assign bus.rvalid0     = r_rvalid0;
  assign bus.rvalid1     = r_rvalid1;
  assign bus.rdata0      = r_rdata0;
  assign bus.rdata1      = r_rdata1;
  assign bus.mem_write   = r_mem_write;
  assign bus.mem_read    = r_mem_read;
  assign bus.mem_address = r_mem_address;
  assign bus.mem_data_in = r_mem_data_in;
endmodule

// File: tb/tb_datamem_arbiter.sv
// Bench for datamem_arbiter: a MEM_LAT=1 instance driven by directed and random traffic
// against a memory/round-robin reference, plus a MEM_LAT=3 instance for latency.
module tb_datamem_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  datamem_arbiter_if b1 ();
  datamem_arbiter_if b3 ();

  datamem_arbiter #(.MEM_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  datamem_arbiter #(.MEM_LAT(3)) dut3 (.clk(clk), .reset(reset), .bus(b3));

  // Memory models: data is only valid exactly MEM_LAT cycles after the sampled read.
  logic [31:0] mem1 [256];
  logic [31:0] p1;
  logic [31:0] mem3 [256];
  logic [31:0] p3 [3];

  always @(posedge clk) begin
    if (b1.mem_write) mem1[b1.mem_address[7:0]] <= b1.mem_data_in;
    p1 <= b1.mem_read ? mem1[b1.mem_address[7:0]] : 32'hDEAD_BEEF;
  end
  assign b1.mem_data_out = p1;

  always @(posedge clk) begin
    if (b3.mem_write) mem3[b3.mem_address[7:0]] <= b3.mem_data_in;
    p3[0] <= b3.mem_read ? mem3[b3.mem_address[7:0]] : 32'hDEAD_BEEF;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign b3.mem_data_out = p3[2];

  typedef struct { int cyc; int c; logic we; logic [31:0] a; logic [31:0] d; } gev_t;
  typedef struct { int cyc; int c; logic [31:0] r0; logic [31:0] r1; } vev_t;
  typedef struct { int c; logic we; int idx; logic [31:0] a; logic [31:0] d; } op_t;

  gev_t gq [$];
  vev_t vq [$];
  op_t  ops [2];
  logic [31:0] ref_mem [16];
  int   last_ref;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals();
    check("rst_gnt0", b1.gnt0, 0);
    check("rst_gnt1", b1.gnt1, 0);
    check("rst_rvalid0", b1.rvalid0, 0);
    check("rst_rvalid1", b1.rvalid1, 0);
    check("rst_mem_write", b1.mem_write, 0);
    check("rst_mem_read", b1.mem_read, 0);
    check("rst_mem_address", b1.mem_address, 0);
    check("rst_mem_data_in", b1.mem_data_in, 0);
    check("rst_rdata0", b1.rdata0, 0);
    check("rst_rdata1", b1.rdata1, 0);
  endtask

  // One client transaction on the MEM_LAT=1 instance; called and returns one tick after a posedge.
  task automatic txn(input int c, input logic we, input logic [31:0] a, input logic [31:0] d);
    logic got;
    if (c == 0) begin b1.req0 = 1'b1; b1.we0 = we; b1.addr0 = a; b1.wdata0 = d; end
    else        begin b1.req1 = 1'b1; b1.we1 = we; b1.addr1 = a; b1.wdata1 = d; end
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = (c == 0) ? b1.gnt0 : b1.gnt1;
    end
    check("gnt_seen", got, 1);
    tick();
    if (c == 0) b1.req0 = 1'b0; else b1.req1 = 1'b0;
    if (!we) begin
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        got = (c == 0) ? b1.rvalid0 : b1.rvalid1;
      end
      check("rvalid_seen", got, 1);
      tick();
    end
  endtask

  initial begin
    int t0, base, vb, vi, pc, n, g3, v3, nrd, first;
    int ord [2];
    logic [31:0] rd3, tmp;
    gev_t g;
    vev_t v;
    op_t  o;

    fork
      forever begin
        @(negedge clk);
        check("gnt_mutex", 32'(b1.gnt0 & b1.gnt1), 0);
        check("rvalid_mutex", 32'(b1.rvalid0 & b1.rvalid1), 0);
        check("cmd_only_with_gnt", 32'(b1.mem_write) + 32'(b1.mem_read), 32'(b1.gnt0 | b1.gnt1));
        if (b1.gnt0 | b1.gnt1) begin
          g.cyc = cyc; g.c = b1.gnt1 ? 1 : 0; g.we = b1.mem_write;
          g.a = b1.mem_address; g.d = b1.mem_data_in;
          gq.push_back(g);
        end
        if (b1.rvalid0 | b1.rvalid1) begin
          v.cyc = cyc; v.c = b1.rvalid1 ? 1 : 0; v.r0 = b1.rdata0; v.r1 = b1.rdata1;
          vq.push_back(v);
        end
      end
    join_none

    reset = 1'b1;
    b1.req0 = 0; b1.req1 = 0; b1.we0 = 0; b1.we1 = 0;
    b1.addr0 = 0; b1.addr1 = 0; b1.wdata0 = 0; b1.wdata1 = 0;
    b3.req0 = 0; b3.req1 = 0; b3.we0 = 0; b3.we1 = 0;
    b3.addr0 = 0; b3.addr1 = 0; b3.wdata0 = 0; b3.wdata1 = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_reset_vals();
    tick();

    // Tie right after reset: client 0 first, then strict alternation at 2-cycle spacing.
    t0 = cyc; base = gq.size();
    fork
      begin for (int k = 0; k < 3; k++) txn(0, 1'b1, 32'(16 + 2 * k), 32'h1000 + 32'(k)); end
      begin for (int k = 0; k < 3; k++) txn(1, 1'b1, 32'(17 + 2 * k), 32'h2000 + 32'(k)); end
    join
    check("alt_count", 32'(gq.size() - base), 6);
    for (int i = 0; i < 6 && base + i < gq.size(); i++) begin
      check("alt_client", 32'(gq[base + i].c), 32'(i % 2));
      check("alt_cycle", 32'(gq[base + i].cyc), 32'(t0 + 1 + 2 * i));
      check("alt_addr", gq[base + i].a, 32'(16 + i));
      check("alt_data", gq[base + i].d, ((i % 2) ? 32'h2000 : 32'h1000) + 32'(i / 2));
    end

    // Client 0 writes 4 to address 3, then reads it back.
    t0 = cyc; base = gq.size(); vb = vq.size();
    txn(0, 1'b1, 32'd3, 32'd4);
    txn(0, 1'b0, 32'd3, 32'd0);
    check("wr_gnt_cycle", 32'(gq[base].cyc), 32'(t0 + 1));
    check("wr_client", 32'(gq[base].c), 0);
    check("wr_mem_write", gq[base].we, 1);
    check("wr_address", gq[base].a, 3);
    check("wr_data_in", gq[base].d, 4);
    check("rd_gnt_cycle", 32'(gq[base + 1].cyc), 32'(t0 + 3));
    check("rd_mem_write", gq[base + 1].we, 0);
    check("rd_rvalid_cycle", 32'(vq[vb].cyc), 32'(t0 + 5));
    check("rd_rvalid_client", 32'(vq[vb].c), 0);
    check("rd_rdata0", vq[vb].r0, 4);

    // Interleaved reads: client 1 was granted last, so client 0 wins the tie.
    t0 = cyc; base = gq.size(); vb = vq.size();
    txn(0, 1'b1, 32'd8, 32'hA5A5_0000);
    txn(1, 1'b1, 32'd9, 32'h0000_5A5A);
    fork
      txn(0, 1'b0, 32'd8, 32'd0);
      txn(1, 1'b0, 32'd9, 32'd0);
    join
    check("il_rvalid_count", 32'(vq.size() - vb), 2);
    check("il_gnt_a_client", 32'(gq[base + 2].c), 0);
    check("il_gnt_a_cycle", 32'(gq[base + 2].cyc), 32'(t0 + 5));
    check("il_gnt_b_client", 32'(gq[base + 3].c), 1);
    check("il_gnt_b_cycle", 32'(gq[base + 3].cyc), 32'(t0 + 9));
    check("il_rv_a_client", 32'(vq[vb].c), 0);
    check("il_rv_a_cycle", 32'(vq[vb].cyc), 32'(t0 + 7));
    check("il_rv_a_rdata0", vq[vb].r0, 32'hA5A5_0000);
    check("il_rv_a_rdata1_hold", vq[vb].r1, 32'd0);
    check("il_rv_b_client", 32'(vq[vb + 1].c), 1);
    check("il_rv_b_cycle", 32'(vq[vb + 1].cyc), 32'(t0 + 11));
    check("il_rv_b_rdata1", vq[vb + 1].r1, 32'h0000_5A5A);
    check("il_rv_b_rdata0_hold", vq[vb + 1].r0, 32'hA5A5_0000);

    // Client 1 raises its request during client 0's WAIT and must wait out the read.
    t0 = cyc; base = gq.size(); vb = vq.size();
    fork
      txn(0, 1'b0, 32'd3, 32'd0);
      begin tick(); tick(); txn(1, 1'b1, 32'd60, 32'h600D_0001); end
    join
    check("held_rv_cycle", 32'(vq[vb].cyc), 32'(t0 + 3));
    check("held_rv_rdata0", vq[vb].r0, 4);
    check("held_gnt_client", 32'(gq[base + 1].c), 1);
    check("held_gnt_cycle", 32'(gq[base + 1].cyc), 32'(t0 + 5));

    // Reset one cycle after a read grant: the read is dropped and everything returns to reset values.
    vb = vq.size();
    b1.req0 = 1'b1; b1.we0 = 1'b0; b1.addr0 = 32'd9;
    @(negedge clk);
    @(negedge clk);
    check("rstw_gnt0", b1.gnt0, 1);
    tick();
    b1.req0 = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals();
    repeat (4) @(negedge clk);
    check("rstw_no_rvalid", 32'(vq.size() - vb), 0);
    tick();
    // last must be back at 1 after reset, so client 0 takes the tie.
    t0 = cyc; base = gq.size(); vb = vq.size();
    fork
      txn(1, 1'b1, 32'd61, 32'h0000_00B1);
      txn(0, 1'b1, 32'd62, 32'h0000_00B0);
    join
    check("rstw_tie_first", 32'(gq[base].c), 0);
    check("rstw_tie_first_cyc", 32'(gq[base].cyc), 32'(t0 + 1));
    check("rstw_tie_second", 32'(gq[base + 1].c), 1);
    t0 = cyc;
    txn(0, 1'b0, 32'd3, 32'd0);
    check("rstw_fresh_rv_cycle", 32'(vq[vb].cyc), 32'(t0 + 3));
    check("rstw_fresh_rdata0", vq[vb].r0, 4);

    // MEM_LAT=3 instance: preload by a write, then read it back.
    b3.req0 = 1'b1; b3.we0 = 1'b1; b3.addr0 = 32'd5; b3.wdata0 = 32'h1234_5678;
    @(negedge clk);
    @(negedge clk);
    check("l3_wr_gnt0", b3.gnt0, 1);
    check("l3_wr_mem_write", b3.mem_write, 1);
    tick();
    b3.req0 = 1'b0;
    tick();
    b3.req0 = 1'b1; b3.we0 = 1'b0;
    g3 = -1; v3 = -1; nrd = 0; rd3 = 32'd0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (b3.gnt0) g3 = k;
      if (b3.mem_read) nrd++;
      if (b3.rvalid0) begin v3 = k; rd3 = b3.rdata0; end
      tick();
      if (g3 >= 0) b3.req0 = 1'b0;
    end
    check("l3_gnt_cycle", 32'(g3), 1);
    check("l3_rvalid_cycle", 32'(v3), 5);
    check("l3_mem_read_cycles", 32'(nrd), 1);
    check("l3_rdata0", rd3, 32'h1234_5678);

    // Random traffic on addresses 32..47 against the reference memory and round-robin rule.
    for (int i = 0; i < 16; i++) begin
      o.c = int'($urandom_range(0, 1));
      tmp = $urandom();
      ref_mem[i] = tmp;
      txn(o.c, 1'b1, 32'(32 + i), tmp);
      last_ref = o.c;
    end
    vi = vq.size();
    for (int s = 0; s < 30; s++) begin
      n = int'($urandom_range(1, 2));
      for (int j = 0; j < 2; j++) begin
        ops[j].c   = (j == 0) ? int'($urandom_range(0, 1)) : 1 - ops[0].c;
        ops[j].we  = 1'($urandom_range(0, 1));
        ops[j].idx = int'($urandom_range(0, 15));
        tmp = $urandom();
        ops[j].a   = {tmp[31:8], 8'(32 + ops[j].idx)};
        ops[j].d   = $urandom();
      end
      t0 = cyc; base = gq.size();
      if (n == 1) begin
        ord[0] = 0;
        txn(ops[0].c, ops[0].we, ops[0].a, ops[0].d);
      end else begin
        first  = (last_ref == 1) ? 0 : 1;
        ord[0] = (ops[0].c == first) ? 0 : 1;
        ord[1] = 1 - ord[0];
        fork
          txn(ops[0].c, ops[0].we, ops[0].a, ops[0].d);
          txn(ops[1].c, ops[1].we, ops[1].a, ops[1].d);
        join
      end
      check("rnd_gnt_count", 32'(gq.size() - base), 32'(n));
      pc = t0 + 1;
      for (int j = 0; j < n && base + j < gq.size(); j++) begin
        o = ops[ord[j]];
        g = gq[base + j];
        check("rnd_gnt_client", 32'(g.c), 32'(o.c));
        check("rnd_gnt_cycle", 32'(g.cyc), 32'(pc));
        check("rnd_mem_write", g.we, o.we);
        check("rnd_address", g.a, o.a);
        if (o.we) begin
          check("rnd_data_in", g.d, o.d);
          ref_mem[o.idx] = o.d;
          pc += 2;
        end else if (vi < vq.size()) begin
          v = vq[vi];
          vi++;
          check("rnd_rv_client", 32'(v.c), 32'(o.c));
          check("rnd_rv_cycle", 32'(v.cyc), 32'(pc + 2));
          check("rnd_rdata", (o.c == 1) ? v.r1 : v.r0, ref_mem[o.idx]);
          pc += 4;
        end
        last_ref = o.c;
      end
    end
    check("rnd_rvalid_total", 32'(vq.size()), 32'(vi));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
